msgpass_rd_sched: RTL and testbench
===================================

Name: msgpass_rd_sched

Overview:
Read scheduler for the message-pass buffer read path. Sequences one decoding pass over LAYER_NUM layers, each RD_PER_LAYER read beats. Drives the read-address generator's buffer_read_begin and is_drc controls, and presents beats downstream under a valid/ready handshake. Sits between the layer controller (start/abort/done) and the message-pass address generator plus SCU.memShare.

Parameters:
LAYER_NUM, 4, layers per pass (>=1)
RD_PER_LAYER, 8, read beats per layer (>=2)
LAYER_W, $clog2(LAYER_NUM) (min 1), layer index width
BEAT_W, $clog2(RD_PER_LAYER), beat index width

Ports:
sys_clk  in  1  system clock
rstn  in  1  reset; asynchronous, active-high (asserted = 1)
start_i  in  1  start a pass; honoured only in IDLE
abort_i  in  1  abandon the pass; honoured in any state
drc1_mask_i  in  RD_PER_LAYER  bit b=1 marks beat b as memShare DRC1; sampled on accepted start
rd_ready_i  in  1  downstream accepts the current beat
buffer_read_begin_o  out  1  one-cycle pulse priming the address generator per layer
is_drc_o  out  MEMSHARE_DRC_NUM  one-hot DRC class of the current beat
rd_valid_o  out  1  current beat valid
addr_en_o  out  1  rd_valid_o & rd_ready_i; advance address generator
layer_idx_o  out  LAYER_W  current layer
beat_idx_o  out  BEAT_W  current beat within layer
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse, pass completed

Behaviour:
- Reset: state IDLE. All outputs 0; counters and mask register 0.
- FSM states: IDLE, BEGIN, READ, DONE. All outputs registered or decoded from state plus registered counters; no combinational path from rd_ready_i except addr_en_o.
- IDLE:
  - start_i=1 and abort_i=0 -> BEGIN, layer=0, beat=0, mask captured.
  - start_i in any other state is ignored.
- BEGIN: buffer_read_begin_o=1 for exactly one cycle; rd_valid_o=0; -> READ.
- READ:
  - rd_valid_o=1.
  - When rd_ready_i=0, outputs and counters hold (stall).
  - An accepted beat (addr_en_o=1) increments beat.
  - Beat RD_PER_LAYER-1 accepted with layer<LAYER_NUM-1: beat wraps to 0, layer+1, -> BEGIN. There is one bubble cycle between layers.
  - Beat RD_PER_LAYER-1 accepted with layer=LAYER_NUM-1: -> DONE.
- DONE: done_o=1 for one cycle; counters cleared; -> IDLE. A start_i in the DONE cycle is ignored.
- is_drc_o:
  - When rd_valid_o=1: bit MEMSHARE_DRC1 = mask[beat], bit MEMSHARE_DRC0 = ~mask[beat].
  - All zero when rd_valid_o=0.
- abort_i=1 in any state: next cycle IDLE, counters cleared, no done_o. Abort has priority over start and over beat acceptance in the same cycle; a beat accepted in the abort cycle still shows addr_en_o=1 that cycle.
- Minimum pass latency with rd_ready_i held at 1: start-to-done = LAYER_NUM*(RD_PER_LAYER+1)+1 cycles (done_o in that cycle after the start cycle).
- Reset asserted mid-pass: immediate return to reset values. No done_o.

Optional Feature:
MSGPASS_RD_SCHED_STALL_CNT_EN:
- When defined, adds output stall_cnt_o (16 bits). It counts cycles with rd_valid_o=1 and rd_ready_i=0, saturates at 16'hFFFF, clears on accepted start, and holds after done.
- When undefined, the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- msgPass_config_pkg gains the typedef rd_sched_state_e (IDLE, BEGIN, READ, DONE) and defaults MSGPASS_LAYER_NUM and MSGPASS_RD_PER_LAYER.
- MEMSHARE_DRC_NUM, MEMSHARE_DRC0 and MEMSHARE_DRC1 come from memShare_config_pkg.
- One natural sub-module, msgpass_rd_beat_cnt: the beat/layer counter pair with wrap and last flags. The FSM stays in the top.

Test Plan:
- Defaults, mask=8'b0000_0000, ready=1 -> 4 begin pulses, 32 beats, is_drc_o always DRC0-only, done_o exactly 37 cycles after start.
- mask=8'b1000_0010, ready=1 -> DRC1 asserted on beats 1 and 7 of every layer, DRC0 on the rest.
- Ready toggling 1,0,0,1 throughout -> beat/layer hold during stalls, 32 accepted beats total. With the macro on, stall_cnt_o = number of stalled valid cycles.
- abort_i at layer 2 beat 3 -> IDLE next cycle, no done_o, new start runs a full clean pass.
- start_i pulsed while busy and in the DONE cycle -> ignored; exactly one done_o per accepted start.
- Reset asserted mid-READ -> all outputs 0 asynchronously, FSM in IDLE, captured mask cleared.

Source files
------------

// File: rtl/msgpass_rd_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | msgpass_rd_sched_pkg                                                 |
// | Shared types and defaults for the message-pass read scheduler.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package msgpass_rd_sched_pkg;

  localparam int MSGPASS_LAYER_NUM    = 4;
  localparam int MSGPASS_RD_PER_LAYER = 8;

  localparam int MEMSHARE_DRC_NUM = 2;
  localparam int MEMSHARE_DRC0    = 0;
  localparam int MEMSHARE_DRC1    = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEGIN = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } rd_sched_state_e;

  // Index width with a floor of one bit so single-entry ranges stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msgpass_rd_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | msgpass_rd_sched_if                                                  |
// | Control/handshake bundle of the read scheduler.                      |
// | Optional: MSGPASS_RD_SCHED_STALL_CNT_EN adds stall_cnt_o.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface msgpass_rd_sched_if
  import msgpass_rd_sched_pkg::*;
#(
  parameter int LAYER_NUM    = MSGPASS_LAYER_NUM,
  parameter int RD_PER_LAYER = MSGPASS_RD_PER_LAYER
);
  localparam int LAYER_W = idx_w(LAYER_NUM);
  localparam int BEAT_W  = idx_w(RD_PER_LAYER);

  logic                        start_i;
  logic                        abort_i;
  logic [RD_PER_LAYER-1:0]     drc1_mask_i;
  logic                        rd_ready_i;
  logic                        buffer_read_begin_o;
  logic [MEMSHARE_DRC_NUM-1:0] is_drc_o;
  logic                        rd_valid_o;
  logic                        addr_en_o;
  logic [LAYER_W-1:0]          layer_idx_o;
  logic [BEAT_W-1:0]           beat_idx_o;
  logic                        busy_o;
  logic                        done_o;
`ifdef MSGPASS_RD_SCHED_STALL_CNT_EN
  logic [15:0]                 stall_cnt_o;
`endif

  modport master (
`ifdef MSGPASS_RD_SCHED_STALL_CNT_EN
    output stall_cnt_o,
`endif
    input  start_i, abort_i, drc1_mask_i, rd_ready_i,
    output buffer_read_begin_o, is_drc_o, rd_valid_o, addr_en_o,
    output layer_idx_o, beat_idx_o, busy_o, done_o
  );

  modport slave (
`ifdef MSGPASS_RD_SCHED_STALL_CNT_EN
    input  stall_cnt_o,
`endif
    output start_i, abort_i, drc1_mask_i, rd_ready_i,
    input  buffer_read_begin_o, is_drc_o, rd_valid_o, addr_en_o,
    input  layer_idx_o, beat_idx_o, busy_o, done_o
  );

endinterface
`default_nettype wire

// File: rtl/msgpass_rd_beat_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | msgpass_rd_beat_cnt                                                  |
// | Beat/layer counter pair with wrap and last-position flags.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module msgpass_rd_beat_cnt
  import msgpass_rd_sched_pkg::*;
#(
  parameter  int LAYER_NUM    = MSGPASS_LAYER_NUM,
  parameter  int RD_PER_LAYER = MSGPASS_RD_PER_LAYER,
  localparam int LAYER_W      = idx_w(LAYER_NUM),
  localparam int BEAT_W       = idx_w(RD_PER_LAYER)
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               i_clr,
  input  wire logic               i_adv,
  output logic      [LAYER_W-1:0] o_layer,
  output logic      [BEAT_W-1:0]  o_beat,
  output logic                    o_beat_last,
  output logic                    o_layer_last
);

  logic [LAYER_W-1:0] r_layer;
  logic [BEAT_W-1:0]  r_beat;
  logic               w_beat_last;
  logic               w_layer_last;

  assign w_beat_last  = (r_beat  == BEAT_W'(RD_PER_LAYER - 1));
  assign w_layer_last = (r_layer == LAYER_W'(LAYER_NUM - 1));

  // The final beat of the final layer wraps both counters to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_layer <= '0;
      r_beat  <= '0;
    end else if (i_clr) begin
      r_layer <= '0;
      r_beat  <= '0;
    end else if (i_adv) begin
      if (w_beat_last) begin
        r_beat  <= '0;
        r_layer <= w_layer_last ? '0 : r_layer + LAYER_W'(1);
      end else begin
        r_beat  <= r_beat + BEAT_W'(1);
      end
    end
  end

  assign o_layer      = r_layer;
  assign o_beat       = r_beat;
  assign o_beat_last  = w_beat_last;
  assign o_layer_last = w_layer_last;

endmodule
`default_nettype wire

// File: rtl/msgpass_rd_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | msgpass_rd_sched                                                     |
// | Read scheduler: one pass of LAYER_NUM layers x RD_PER_LAYER beats.   |
// | Optional: MSGPASS_RD_SCHED_STALL_CNT_EN adds a saturating stall cnt. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module msgpass_rd_sched
  import msgpass_rd_sched_pkg::*;
#(
  parameter int LAYER_NUM    = MSGPASS_LAYER_NUM,
  parameter int RD_PER_LAYER = MSGPASS_RD_PER_LAYER
) (
  input wire logic             sys_clk,
  input wire logic             rstn,
  msgpass_rd_sched_if.master   bus
);

  localparam int LAYER_W = idx_w(LAYER_NUM);
  localparam int BEAT_W  = idx_w(RD_PER_LAYER);

  rd_sched_state_e             r_state;
  logic [RD_PER_LAYER-1:0]     r_mask;
  logic [LAYER_W-1:0]          w_layer;
  logic [BEAT_W-1:0]           w_beat;
  logic                        w_beat_last;
  logic                        w_layer_last;
  logic                        w_start_acc;
  logic                        w_valid;
  logic                        w_accept;
  logic                        w_cnt_clr;
  logic [MEMSHARE_DRC_NUM-1:0] w_is_drc;

  assign w_start_acc = (r_state == IDLE) & bus.start_i & ~bus.abort_i;
  assign w_valid     = (r_state == READ);
  assign w_accept    = w_valid & bus.rd_ready_i;
  assign w_cnt_clr   = bus.abort_i | w_start_acc | (r_state == DONE);

  msgpass_rd_beat_cnt #(
    .LAYER_NUM    (LAYER_NUM),
    .RD_PER_LAYER (RD_PER_LAYER)
  ) u_beat_cnt (
    .clk          (sys_clk),
    .rst          (rstn),
    .i_clr        (w_cnt_clr),
    .i_adv        (w_accept),
    .o_layer      (w_layer),
    .o_beat       (w_beat),
    .o_beat_last  (w_beat_last),
    .o_layer_last (w_layer_last)
  );

  // Abort overrides every transition, including a same-cycle start.
  always_ff @(posedge sys_clk or posedge rstn) begin
    if (rstn) begin
      r_state <= IDLE;
      r_mask  <= '0;
    end else if (bus.abort_i) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            r_state <= BEGIN;
            r_mask  <= bus.drc1_mask_i;
          end
        end
        BEGIN:   r_state <= READ;
        READ: begin
          if (w_accept && w_beat_last) begin
            r_state <= w_layer_last ? DONE : BEGIN;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_is_drc = '0;
    if (w_valid) begin
      w_is_drc[MEMSHARE_DRC1] = r_mask[w_beat];
      w_is_drc[MEMSHARE_DRC0] = ~r_mask[w_beat];
    end
  end

  assign bus.buffer_read_begin_o = (r_state == BEGIN);
  assign bus.rd_valid_o          = w_valid;
  assign bus.addr_en_o           = w_accept;
  assign bus.is_drc_o            = w_is_drc;
  assign bus.layer_idx_o         = w_layer;
  assign bus.beat_idx_o          = w_beat;
  assign bus.busy_o              = (r_state != IDLE);
  assign bus.done_o              = (r_state == DONE);

`ifdef MSGPASS_RD_SCHED_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Cleared only by a new pass so the count survives for readout after done.
  always_ff @(posedge sys_clk or posedge rstn) begin
    if (rstn) begin
      r_stall_cnt <= '0;
    end else if (w_start_acc) begin
      r_stall_cnt <= '0;
    end else if (w_valid && !bus.rd_ready_i && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_msgpass_rd_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_msgpass_rd_sched                                                  |
// | Directed bench with a pass-level model checked every negedge.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_msgpass_rd_sched;
  import msgpass_rd_sched_pkg::*;

  localparam int N = MSGPASS_LAYER_NUM;
  localparam int R = MSGPASS_RD_PER_LAYER;

  logic sys_clk = 1'b0;
  logic rstn    = 1'b1;
  always #5 sys_clk = ~sys_clk;

  msgpass_rd_sched_if bus ();

  msgpass_rd_sched dut (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int n_begin, n_beat, n_drc1, n_done, done_cyc;
  int st_cyc;
  bit ready_mode;
  int pidx;

  // Pass-level model: progress is the number of accepted beats in the pass.
  bit          m_busy, m_begun, m_done;
  int          m_acc;
  logic [R-1:0] m_mask;
  int          m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    logic       e_valid, e_begin, e_done, e_busy, e_addr;
    int         e_layer, e_beat;
    logic [1:0] e_drc;
    if (rstn) begin
      m_busy = 0; m_begun = 0; m_done = 0; m_acc = 0; m_mask = '0; m_stall = 0;
    end
    e_valid = 0; e_begin = 0; e_done = 0; e_busy = 0;
    e_layer = 0; e_beat = 0; e_drc = '0;
    if (m_busy) begin
      e_busy = 1;
      if (m_done) e_done = 1;
      else if (!m_begun) begin
        e_begin = 1;
        e_layer = m_acc / R;
      end else begin
        e_valid = 1;
        e_layer = m_acc / R;
        e_beat  = m_acc % R;
        e_drc[MEMSHARE_DRC1] = m_mask[e_beat];
        e_drc[MEMSHARE_DRC0] = ~m_mask[e_beat];
      end
    end
    e_addr = e_valid & bus.rd_ready_i & ~rstn;
    chk("busy",   {31'd0, bus.busy_o},              {31'd0, e_busy});
    chk("valid",  {31'd0, bus.rd_valid_o},          {31'd0, e_valid});
    chk("begin",  {31'd0, bus.buffer_read_begin_o}, {31'd0, e_begin});
    chk("done",   {31'd0, bus.done_o},              {31'd0, e_done});
    chk("addr_en",{31'd0, bus.addr_en_o},           {31'd0, e_addr});
    chk("layer",  32'(bus.layer_idx_o),             32'(e_layer));
    chk("beat",   32'(bus.beat_idx_o),              32'(e_beat));
    chk("is_drc", 32'(bus.is_drc_o),                32'(e_drc));
`ifdef MSGPASS_RD_SCHED_STALL_CNT_EN
    chk("stall_cnt", 32'(bus.stall_cnt_o),          32'(m_stall));
`endif
    if (bus.buffer_read_begin_o) n_begin++;
    if (bus.addr_en_o) n_beat++;
    if (bus.addr_en_o && bus.is_drc_o[MEMSHARE_DRC1]) n_drc1++;
    if (bus.done_o) begin n_done++; done_cyc = cyc; end
    if (!rstn) begin
      if (e_valid && !bus.rd_ready_i && m_stall != 16'hFFFF) m_stall++;
      if (bus.abort_i) m_busy = 0;
      else if (!m_busy) begin
        if (bus.start_i) begin
          m_busy = 1; m_acc = 0; m_begun = 0; m_done = 0;
          m_mask = bus.drc1_mask_i; m_stall = 0;
        end
      end else if (m_done) m_busy = 0;
      else if (!m_begun) m_begun = 1;
      else if (bus.rd_ready_i) begin
        m_acc++;
        if (m_acc == N * R) m_done = 1;
        else if (m_acc % R == 0) m_begun = 0;
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (ready_mode) begin
      pidx++;
      bus.rd_ready_i = (pidx % 4 == 0) || (pidx % 4 == 3);
    end else begin
      bus.rd_ready_i = 1'b1;
    end
  endtask

  task automatic clear_stats();
    n_begin = 0; n_beat = 0; n_drc1 = 0; n_done = 0; done_cyc = 0;
  endtask

  task automatic start_pass(input logic [R-1:0] mask);
    bus.drc1_mask_i = mask;
    bus.start_i     = 1'b1;
    st_cyc          = cyc;
    tick();
    bus.start_i     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      tick();
      k++;
    end
    if (n_done == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL pass_timeout actual=no_done expected=done_within_%0d", budget);
    end
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 0; bus.abort_i = 0; bus.drc1_mask_i = '0; bus.rd_ready_i = 1;
    ready_mode = 0; pidx = 0;
    clear_stats();
    repeat (3) tick();
    chk("rst_busy",  {31'd0, bus.busy_o},     32'd0);
    chk("rst_valid", {31'd0, bus.rd_valid_o}, 32'd0);
    chk("rst_layer", 32'(bus.layer_idx_o),    32'd0);
    rstn = 1'b0;
    repeat (2) tick();

    // Mask all-zero, ready held high: minimum-latency pass.
    clear_stats();
    start_pass(8'b0000_0000);
    wait_done(200);
    chk("t1_begins", n_begin, 4);
    chk("t1_beats",  n_beat, 32);
    chk("t1_drc1",   n_drc1, 0);
    chk("t1_latency", done_cyc - st_cyc, 37);
    chk("t1_dones",  n_done, 1);

    // DRC1 on beats 1 and 7 of every layer.
    clear_stats();
    start_pass(8'b1000_0010);
    wait_done(200);
    chk("t2_beats", n_beat, 32);
    chk("t2_drc1",  n_drc1, 8);

    // Ready pattern 1,0,0,1 throughout.
    clear_stats();
    ready_mode = 1; pidx = 0;
    start_pass(8'b0101_1010);
    wait_done(400);
    ready_mode = 0;
    tick();
    chk("t3_beats",  n_beat, 32);
    chk("t3_begins", n_begin, 4);
    chk("t3_dones",  n_done, 1);

    // Abort at layer 2, beat 3 (cycle 23 after the start cycle).
    clear_stats();
    start_pass(8'h00);
    repeat (22) tick();
    chk("t4_at_layer", 32'(bus.layer_idx_o), 32'd2);
    chk("t4_at_beat",  32'(bus.beat_idx_o),  32'd3);
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chk("t4_idle", {31'd0, bus.busy_o}, 32'd0);
    repeat (5) tick();
    chk("t4_no_done", n_done, 0);
    chk("t4_beats",   n_beat, 20);
    clear_stats();
    start_pass(8'h81);
    wait_done(200);
    chk("t4_clean_beats", n_beat, 32);
    chk("t4_clean_done",  n_done, 1);

    // Start while busy and in the DONE cycle must be ignored.
    clear_stats();
    start_pass(8'h00);
    repeat (4) tick();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int k = 0; k < 100 && cyc < st_cyc + 37; k++) tick();
    chk("t5_in_done", {31'd0, bus.done_o}, 32'd1);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    repeat (5) tick();
    chk("t5_dones",  n_done, 1);
    chk("t5_idle",   {31'd0, bus.busy_o}, 32'd0);
    chk("t5_begins", n_begin, 4);

    // Asynchronous reset mid-READ.
    clear_stats();
    start_pass(8'hFF);
    repeat (12) tick();
    rstn = 1'b1;
    #1;
    chk("t6_busy",  {31'd0, bus.busy_o},     32'd0);
    chk("t6_valid", {31'd0, bus.rd_valid_o}, 32'd0);
    chk("t6_drc",   32'(bus.is_drc_o),       32'd0);
    chk("t6_beat",  32'(bus.beat_idx_o),     32'd0);
    chk("t6_layer", 32'(bus.layer_idx_o),    32'd0);
    repeat (2) tick();
    rstn = 1'b0;
    tick();
    clear_stats();
    start_pass(8'h00);
    wait_done(200);
    chk("t6_after_dones", n_done, 1);
    chk("t6_after_drc1",  n_drc1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
